tl_a_arbiter: RTL and testbench



---
 rtl/tl_a_arbiter_pkg.sv | 40 ++++
 rtl/tl_rr_pick.sv | 32 +++
 rtl/tl_a_arbiter.sv | 180 ++++++++++++++++++
 tb/tb_tl_a_arbiter.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tl_a_arbiter_pkg.sv
// Shared TileLink field widths, opcodes, arbiter state encodings and the A-channel slice record.
package tl_a_arbiter_pkg;

  localparam int TL_SIZE_BITS   = 3;
  localparam int TL_SOURCE_BITS = 4;
  localparam int TL_SINK_BITS   = 2;
  localparam int TL_ADDR_BITS   = 32;
  localparam int TL_DATA_BYTES  = 4;
  localparam int TL_DATA_BITS   = TL_DATA_BYTES * 8;

  localparam logic [2:0] TL_A_PUTFULL    = 3'd0;
  localparam logic [2:0] TL_A_PUTPARTIAL = 3'd1;
  localparam logic [2:0] TL_A_GET        = 3'd4;

  localparam logic [3:0] TL_D_ACCESSACK     = 4'd0;
  localparam logic [3:0] TL_D_ACCESSACKDATA = 4'd1;

  typedef enum logic [1:0] {
    TL_ARB_S_IDLE = 2'd0,
    TL_ARB_S_FWD  = 2'd1,
    TL_ARB_S_RESP = 2'd2,
    TL_ARB_S_DENY = 2'd3
  } tl_arb_state_e;

  typedef struct packed {
    logic [2:0]                opcode;
    logic [2:0]                param;
    logic [TL_SIZE_BITS-1:0]   size;
    logic [TL_SOURCE_BITS-1:0] source;
    logic [TL_ADDR_BITS-1:0]   address;
    logic [TL_DATA_BYTES-1:0]  mask;
    logic [TL_DATA_BITS-1:0]   data;
  } tl_a_t;

  // The slave only implements plain reads and writes; everything else is denied locally.
  function automatic logic tl_a_supported(input logic [2:0] op);
    return (op == TL_A_GET) || (op == TL_A_PUTFULL) || (op == TL_A_PUTPARTIAL);
  endfunction

endpackage

// File: rtl/tl_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping modulo N.
module tl_rr_pick #(
  parameter int N     = 2,
  parameter int IDX_W = 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic             any,
  output logic [IDX_W-1:0] idx
);

  localparam logic [IDX_W:0] N_W = (IDX_W+1)'(N);

  logic [N-1:0]   rot;
  logic [IDX_W:0] off;
  logic [IDX_W:0] sum;

  // Rotate so bit 0 is the requester at ptr, then take the lowest set bit.
  assign rot = N'({req, req} >> ptr);

  always_comb begin
    off = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (rot[k]) off = (IDX_W+1)'(k);
    end
  end

  assign sum = off + {1'b0, ptr};
  assign idx = (sum >= N_W) ? IDX_W'(sum - N_W) : IDX_W'(sum);
  assign any = |req;

endmodule

// File: rtl/tl_a_arbiter.sv
// Round-robin arbiter sharing one single-outstanding TileLink slave among N masters; grant held A-accept to D-handshake.
// Unsupported A opcodes are answered locally with a denied AccessAck.
module tl_a_arbiter
  import tl_a_arbiter_pkg::*;
#(
  parameter int N_MASTERS = 2,
  parameter int IDX_W     = (N_MASTERS > 2) ? $clog2(N_MASTERS) : 1
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [N_MASTERS-1:0]                m_a_valid,
  output logic [N_MASTERS-1:0]                m_a_ready,
  input  logic [N_MASTERS*3-1:0]              m_a_opcode,
  input  logic [N_MASTERS*3-1:0]              m_a_param,
  input  logic [N_MASTERS*TL_SIZE_BITS-1:0]   m_a_size,
  input  logic [N_MASTERS*TL_SOURCE_BITS-1:0] m_a_source,
  input  logic [N_MASTERS*TL_ADDR_BITS-1:0]   m_a_address,
  input  logic [N_MASTERS*TL_DATA_BYTES-1:0]  m_a_mask,
  input  logic [N_MASTERS*TL_DATA_BITS-1:0]   m_a_data,
  output logic [N_MASTERS-1:0]                m_d_valid,
  input  logic [N_MASTERS-1:0]                m_d_ready,
  output logic [3:0]                          m_d_opcode,
  output logic [1:0]                          m_d_param,
  output logic [TL_SIZE_BITS-1:0]             m_d_size,
  output logic [TL_SOURCE_BITS-1:0]           m_d_source,
  output logic [TL_SINK_BITS-1:0]             m_d_sink,
  output logic                                m_d_denied,
  output logic [TL_DATA_BITS-1:0]             m_d_data,
  output logic                                s_a_valid,
  input  logic                                s_a_ready,
  output logic [2:0]                          s_a_opcode,
  output logic [2:0]                          s_a_param,
  output logic [TL_SIZE_BITS-1:0]             s_a_size,
  output logic [TL_SOURCE_BITS-1:0]           s_a_source,
  output logic [TL_ADDR_BITS-1:0]             s_a_address,
  output logic [TL_DATA_BYTES-1:0]            s_a_mask,
  output logic [TL_DATA_BITS-1:0]             s_a_data,
  input  logic                                s_d_valid,
  output logic                                s_d_ready,
  input  logic [3:0]                          s_d_opcode,
  input  logic [1:0]                          s_d_param,
  input  logic [TL_SIZE_BITS-1:0]             s_d_size,
  input  logic [TL_SOURCE_BITS-1:0]           s_d_source,
  input  logic [TL_SINK_BITS-1:0]             s_d_sink,
  input  logic                                s_d_denied,
  input  logic [TL_DATA_BITS-1:0]             s_d_data,
  output logic                                busy,
  output logic [IDX_W-1:0]                    grant_idx
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_MASTERS - 1);

  tl_arb_state_e             state, state_nxt;
  logic [IDX_W-1:0]          rr_ptr, rr_ptr_nxt, grant_nxt, pick_idx, rr_adv;
  logic                      pick_any;
  logic [TL_SOURCE_BITS-1:0] deny_source, deny_source_nxt;
  logic [TL_SIZE_BITS-1:0]   deny_size, deny_size_nxt;
  tl_a_t                     a_slice [N_MASTERS];
  tl_a_t                     a_sel;
  logic                      sel_legal;
  logic                      owner_d_ready;

  for (genvar i = 0; i < N_MASTERS; i++) begin : g_unpack
    assign a_slice[i] = {m_a_opcode[3*i +: 3], m_a_param[3*i +: 3],
                         m_a_size[TL_SIZE_BITS*i +: TL_SIZE_BITS],
                         m_a_source[TL_SOURCE_BITS*i +: TL_SOURCE_BITS],
                         m_a_address[TL_ADDR_BITS*i +: TL_ADDR_BITS],
                         m_a_mask[TL_DATA_BYTES*i +: TL_DATA_BYTES],
                         m_a_data[TL_DATA_BITS*i +: TL_DATA_BITS]};
  end

  tl_rr_pick #(.N(N_MASTERS), .IDX_W(IDX_W)) u_pick (
    .req (m_a_valid),
    .ptr (rr_ptr),
    .any (pick_any),
    .idx (pick_idx)
  );

  assign a_sel         = a_slice[grant_idx];
  assign sel_legal     = tl_a_supported(a_sel.opcode);
  assign owner_d_ready = m_d_ready[grant_idx];
  assign rr_adv        = (grant_idx == LAST_IDX) ? '0 : grant_idx + 1'b1;
  assign busy          = (state != TL_ARB_S_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= TL_ARB_S_IDLE;
      rr_ptr      <= '0;
      grant_idx   <= '0;
      deny_source <= '0;
      deny_size   <= '0;
    end else begin
      state       <= state_nxt;
      rr_ptr      <= rr_ptr_nxt;
      grant_idx   <= grant_nxt;
      deny_source <= deny_source_nxt;
      deny_size   <= deny_size_nxt;
    end
  end

  always_comb begin
    state_nxt       = state;
    rr_ptr_nxt      = rr_ptr;
    grant_nxt       = grant_idx;
    deny_source_nxt = deny_source;
    deny_size_nxt   = deny_size;
    m_a_ready       = '0;
    m_d_valid       = '0;
    m_d_opcode      = '0;
    m_d_param       = '0;
    m_d_size        = '0;
    m_d_source      = '0;
    m_d_sink        = '0;
    m_d_denied      = 1'b0;
    m_d_data        = '0;
    s_a_valid       = 1'b0;
    s_a_opcode      = '0;
    s_a_param       = '0;
    s_a_size        = '0;
    s_a_source      = '0;
    s_a_address     = '0;
    s_a_mask        = '0;
    s_a_data        = '0;
    s_d_ready       = 1'b0;
    unique case (state)
      TL_ARB_S_IDLE: begin
        if (pick_any) begin
          grant_nxt = pick_idx;
          state_nxt = TL_ARB_S_FWD;
        end
      end
      TL_ARB_S_FWD: begin
        if (sel_legal) begin
          s_a_valid            = 1'b1;
          s_a_opcode           = a_sel.opcode;
          s_a_param            = a_sel.param;
          s_a_size             = a_sel.size;
          s_a_source           = a_sel.source;
          s_a_address          = a_sel.address;
          s_a_mask             = a_sel.mask;
          s_a_data             = a_sel.data;
          m_a_ready[grant_idx] = s_a_ready;
          if (s_a_ready) begin
            rr_ptr_nxt = rr_adv;
            state_nxt  = TL_ARB_S_RESP;
          end
        end else begin
          // Swallow the request in one cycle and remember what the denial must echo.
          m_a_ready[grant_idx] = 1'b1;
          deny_source_nxt      = a_sel.source;
          deny_size_nxt        = a_sel.size;
          rr_ptr_nxt           = rr_adv;
          state_nxt            = TL_ARB_S_DENY;
        end
      end
      TL_ARB_S_RESP: begin
        m_d_valid[grant_idx] = s_d_valid;
        s_d_ready            = owner_d_ready;
        m_d_opcode           = s_d_opcode;
        m_d_param            = s_d_param;
        m_d_size             = s_d_size;
        m_d_source           = s_d_source;
        m_d_sink             = s_d_sink;
        m_d_denied           = s_d_denied;
        m_d_data             = s_d_data;
        if (s_d_valid && owner_d_ready) state_nxt = TL_ARB_S_IDLE;
      end
      TL_ARB_S_DENY: begin
        m_d_valid[grant_idx] = 1'b1;
        m_d_opcode           = TL_D_ACCESSACK;
        m_d_denied           = 1'b1;
        m_d_source           = deny_source;
        m_d_size             = deny_size;
        if (owner_d_ready) state_nxt = TL_ARB_S_IDLE;
      end
      default: state_nxt = TL_ARB_S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_tl_a_arbiter.sv
// Directed bench: table of single transactions plus contention, back-pressure, reset and fairness sequences.
`timescale 1ns/1ps
module tb_tl_a_arbiter;
  import tl_a_arbiter_pkg::*;

  localparam int N  = 2;
  localparam int NB = 4;
  localparam int SZ = TL_SIZE_BITS;
  localparam int SR = TL_SOURCE_BITS;
  localparam int AW = TL_ADDR_BITS;
  localparam int DB = TL_DATA_BYTES;
  localparam int DW = TL_DATA_BITS;
  localparam int SK = TL_SINK_BITS;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [N-1:0] m_a_valid, m_a_ready, m_d_valid, m_d_ready;
  logic [N*3-1:0] m_a_opcode, m_a_param;
  logic [N*SZ-1:0] m_a_size;
  logic [N*SR-1:0] m_a_source;
  logic [N*AW-1:0] m_a_address;
  logic [N*DB-1:0] m_a_mask;
  logic [N*DW-1:0] m_a_data;
  logic [3:0] m_d_opcode, s_d_opcode;
  logic [1:0] m_d_param, s_d_param;
  logic [SZ-1:0] m_d_size, s_a_size, s_d_size;
  logic [SR-1:0] m_d_source, s_a_source, s_d_source;
  logic [SK-1:0] m_d_sink, s_d_sink;
  logic m_d_denied, s_d_denied, s_a_valid, s_a_ready, s_d_valid, s_d_ready, busy;
  logic [DW-1:0] m_d_data, s_a_data, s_d_data;
  logic [2:0] s_a_opcode, s_a_param;
  logic [AW-1:0] s_a_address;
  logic [DB-1:0] s_a_mask;
  logic [0:0] grant_idx;

  logic [NB-1:0] b_m_a_valid, b_m_a_ready, b_m_d_valid, b_m_d_ready;
  logic [NB*3-1:0] b_m_a_opcode, b_m_a_param;
  logic [NB*SZ-1:0] b_m_a_size;
  logic [NB*SR-1:0] b_m_a_source;
  logic [NB*AW-1:0] b_m_a_address;
  logic [NB*DB-1:0] b_m_a_mask;
  logic [NB*DW-1:0] b_m_a_data;
  logic [3:0] b_m_d_opcode;
  logic [1:0] b_m_d_param;
  logic [SZ-1:0] b_m_d_size, b_s_a_size;
  logic [SR-1:0] b_m_d_source, b_s_a_source;
  logic [SK-1:0] b_m_d_sink;
  logic b_m_d_denied, b_s_a_valid, b_s_a_ready, b_s_d_valid, b_s_d_ready, b_busy;
  logic [DW-1:0] b_m_d_data, b_s_a_data;
  logic [2:0] b_s_a_opcode, b_s_a_param;
  logic [AW-1:0] b_s_a_address;
  logic [DB-1:0] b_s_a_mask;
  logic [1:0] b_grant_idx;

  tl_a_arbiter #(.N_MASTERS(N)) dut (
    .clk(clk), .rst(rst),
    .m_a_valid(m_a_valid), .m_a_ready(m_a_ready), .m_a_opcode(m_a_opcode), .m_a_param(m_a_param),
    .m_a_size(m_a_size), .m_a_source(m_a_source), .m_a_address(m_a_address), .m_a_mask(m_a_mask),
    .m_a_data(m_a_data), .m_d_valid(m_d_valid), .m_d_ready(m_d_ready), .m_d_opcode(m_d_opcode),
    .m_d_param(m_d_param), .m_d_size(m_d_size), .m_d_source(m_d_source), .m_d_sink(m_d_sink),
    .m_d_denied(m_d_denied), .m_d_data(m_d_data),
    .s_a_valid(s_a_valid), .s_a_ready(s_a_ready), .s_a_opcode(s_a_opcode), .s_a_param(s_a_param),
    .s_a_size(s_a_size), .s_a_source(s_a_source), .s_a_address(s_a_address), .s_a_mask(s_a_mask),
    .s_a_data(s_a_data), .s_d_valid(s_d_valid), .s_d_ready(s_d_ready), .s_d_opcode(s_d_opcode),
    .s_d_param(s_d_param), .s_d_size(s_d_size), .s_d_source(s_d_source), .s_d_sink(s_d_sink),
    .s_d_denied(s_d_denied), .s_d_data(s_d_data), .busy(busy), .grant_idx(grant_idx)
  );

  tl_a_arbiter #(.N_MASTERS(NB)) dut_b (
    .clk(clk), .rst(rst),
    .m_a_valid(b_m_a_valid), .m_a_ready(b_m_a_ready), .m_a_opcode(b_m_a_opcode), .m_a_param(b_m_a_param),
    .m_a_size(b_m_a_size), .m_a_source(b_m_a_source), .m_a_address(b_m_a_address), .m_a_mask(b_m_a_mask),
    .m_a_data(b_m_a_data), .m_d_valid(b_m_d_valid), .m_d_ready(b_m_d_ready), .m_d_opcode(b_m_d_opcode),
    .m_d_param(b_m_d_param), .m_d_size(b_m_d_size), .m_d_source(b_m_d_source), .m_d_sink(b_m_d_sink),
    .m_d_denied(b_m_d_denied), .m_d_data(b_m_d_data),
    .s_a_valid(b_s_a_valid), .s_a_ready(b_s_a_ready), .s_a_opcode(b_s_a_opcode), .s_a_param(b_s_a_param),
    .s_a_size(b_s_a_size), .s_a_source(b_s_a_source), .s_a_address(b_s_a_address), .s_a_mask(b_s_a_mask),
    .s_a_data(b_s_a_data), .s_d_valid(b_s_d_valid), .s_d_ready(b_s_d_ready), .s_d_opcode(TL_D_ACCESSACKDATA),
    .s_d_param(2'd0), .s_d_size(3'd2), .s_d_source(4'd0), .s_d_sink(2'd0),
    .s_d_denied(1'b0), .s_d_data(32'h0), .busy(b_busy), .grant_idx(b_grant_idx)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    int            m;
    logic [2:0]    op;
    logic [SR-1:0] src;
    logic [SZ-1:0] sz;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
    logic          fwd;
    logic [3:0]    d_op;
    logic          d_denied;
    logic [DW-1:0] d_data;
  } vec_t;

  vec_t vecs[6];

  task automatic set_master(input int m, input logic [2:0] op, input logic [SR-1:0] src,
                            input logic [SZ-1:0] sz, input logic [AW-1:0] addr, input logic [DW-1:0] data);
    m_a_opcode[3*m +: 3]     = op;
    m_a_param[3*m +: 3]      = 3'd0;
    m_a_size[SZ*m +: SZ]     = sz;
    m_a_source[SR*m +: SR]   = src;
    m_a_address[AW*m +: AW]  = addr;
    m_a_mask[DB*m +: DB]     = '1;
    m_a_data[DW*m +: DW]     = data;
    m_a_valid[m]             = 1'b1;
  endtask

  // Entered on a negedge with the arbiter idle; leaves on a negedge with it idle again.
  task automatic run_vec(input vec_t v, input int k);
    logic [N-1:0] oh;
    oh = '0;
    oh[v.m] = 1'b1;
    set_master(v.m, v.op, v.src, v.sz, v.addr, v.wdata);
    @(negedge clk);
    check($sformatf("v%0d grant", k), grant_idx, v.m);
    check($sformatf("v%0d busy", k), busy, 1);
    check($sformatf("v%0d s_a_valid", k), s_a_valid, v.fwd);
    if (v.fwd) begin
      check($sformatf("v%0d s_a_addr", k), s_a_address, v.addr);
      check($sformatf("v%0d s_a_src", k), s_a_source, v.src);
      check($sformatf("v%0d s_a_data", k), {s_a_opcode, s_a_size, s_a_data}, {v.op, v.sz, v.wdata});
      check($sformatf("v%0d a_ready_wait", k), m_a_ready, 0);
      s_a_ready = 1'b1;
      #1;
    end
    check($sformatf("v%0d a_ready", k), m_a_ready, oh);
    @(negedge clk);
    m_a_valid[v.m] = 1'b0;
    s_a_ready = 1'b0;
    if (v.fwd) begin
      s_d_valid = 1'b1; s_d_opcode = v.d_op; s_d_source = v.src; s_d_size = v.sz;
      s_d_data = v.rdata; s_d_denied = 1'b0; s_d_sink = 2'd1; s_d_param = 2'd0;
    end
    m_d_ready = oh;
    #1;
    check($sformatf("v%0d d_valid", k), m_d_valid, oh);
    check($sformatf("v%0d d_op", k), {m_d_opcode, m_d_denied, m_d_param}, {v.d_op, v.d_denied, 2'd0});
    check($sformatf("v%0d d_src_size", k), {m_d_source, m_d_size}, {v.src, v.sz});
    check($sformatf("v%0d d_data", k), m_d_data, v.d_data);
    check($sformatf("v%0d d_sink", k), m_d_sink, v.fwd ? 2'd1 : 2'd0);
    check($sformatf("v%0d s_d_ready", k), s_d_ready, v.fwd);
    check($sformatf("v%0d no_s_a", k), s_a_valid, 0);
    @(negedge clk);
    s_d_valid = 1'b0; m_d_ready = '0; s_d_opcode = '0; s_d_source = '0; s_d_size = '0;
    s_d_data = '0; s_d_sink = '0;
    #1;
    check($sformatf("v%0d idle", k), {busy, m_d_valid}, 0);
  endtask

  // Serves whichever legal request is forwarded next and checks who owns it.
  task automatic serve_one(input string name, input int expk);
    logic [N-1:0] oh;
    int g;
    oh = '0;
    oh[expk] = 1'b1;
    for (int t = 0; t < 8 && s_a_valid !== 1'b1; t++) @(negedge clk);
    check({name, " a_valid"}, s_a_valid, 1);
    check({name, " grant"}, grant_idx, expk);
    g = int'(grant_idx);
    s_a_ready = 1'b1;
    @(negedge clk);
    s_a_ready = 1'b0;
    m_a_valid[g] = 1'b0;
    s_d_valid = 1'b1; s_d_opcode = TL_D_ACCESSACK;
    m_d_ready = '1;
    #1;
    check({name, " d_valid"}, m_d_valid, oh);
    @(negedge clk);
    s_d_valid = 1'b0; m_d_ready = '0;
  endtask

  task automatic serve_pair(input string name, input int e0, input int e1);
    set_master(0, TL_A_PUTFULL, 4'd1, 3'd2, 32'h1000, 32'hAAAA0000);
    set_master(1, TL_A_PUTFULL, 4'd2, 3'd2, 32'h2000, 32'hBBBB0000);
    serve_one({name, "[0]"}, e0);
    serve_one({name, "[1]"}, e1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  int cnt[NB];

  initial begin
    m_a_valid = '0; m_a_opcode = '0; m_a_param = '0; m_a_size = '0; m_a_source = '0;
    m_a_address = '0; m_a_mask = '0; m_a_data = '0; m_d_ready = '0;
    s_a_ready = 1'b0; s_d_valid = 1'b0; s_d_opcode = '0; s_d_param = '0; s_d_size = '0;
    s_d_source = '0; s_d_sink = '0; s_d_denied = 1'b0; s_d_data = '0;
    b_m_a_valid = '0; b_m_a_opcode = {NB{TL_A_GET}}; b_m_a_param = '0; b_m_a_size = '0;
    b_m_a_source = '0; b_m_a_address = '0; b_m_a_mask = '0; b_m_a_data = '0;
    b_m_d_ready = '0; b_s_a_ready = 1'b0; b_s_d_valid = 1'b0;

    vecs[0] = '{m:1, op:TL_A_GET,        src:4'd3, sz:3'd2, addr:32'h40,  wdata:32'h0,
                rdata:32'hCAFEF00D, fwd:1, d_op:TL_D_ACCESSACKDATA, d_denied:0, d_data:32'hCAFEF00D};
    vecs[1] = '{m:0, op:TL_A_PUTFULL,    src:4'd1, sz:3'd2, addr:32'h100, wdata:32'h11223344,
                rdata:32'h0, fwd:1, d_op:TL_D_ACCESSACK, d_denied:0, d_data:32'h0};
    vecs[2] = '{m:1, op:3'd6,            src:4'd2, sz:3'd3, addr:32'h80,  wdata:32'h0,
                rdata:32'h0, fwd:0, d_op:TL_D_ACCESSACK, d_denied:1, d_data:32'h0};
    vecs[3] = '{m:1, op:TL_A_PUTPARTIAL, src:4'd7, sz:3'd1, addr:32'h8,   wdata:32'h0000BEEF,
                rdata:32'h0, fwd:1, d_op:TL_D_ACCESSACK, d_denied:0, d_data:32'h0};
    vecs[4] = '{m:0, op:3'd2,            src:4'd9, sz:3'd0, addr:32'hC,   wdata:32'h1,
                rdata:32'h0, fwd:0, d_op:TL_D_ACCESSACK, d_denied:1, d_data:32'h0};
    vecs[5] = '{m:0, op:3'b101,          src:4'd5, sz:3'd2, addr:32'h200, wdata:32'h0,
                rdata:32'h0, fwd:0, d_op:TL_D_ACCESSACK, d_denied:1, d_data:32'h0};

    repeat (3) @(negedge clk);
    check("rst busy", {busy, b_busy}, 0);
    check("rst grant", {grant_idx, b_grant_idx}, 0);
    check("rst valids", {m_a_ready, m_d_valid, s_a_valid, s_d_ready}, 0);
    check("rst fields", {s_a_address, s_a_data, m_d_opcode, m_d_data}, 0);
    rst = 1'b0;

    // A stray D beat while idle must be ignored.
    s_d_valid = 1'b1; s_d_data = 32'h12345678;
    @(negedge clk);
    check("stray s_d_ready", s_d_ready, 0);
    check("stray d_valid", {busy, m_d_valid, m_d_data}, 0);
    s_d_valid = 1'b0; s_d_data = '0;

    serve_pair("contend1", 0, 1);
    for (int k = 0; k < 6; k++) run_vec(vecs[k], k);
    // Last vector was master 0 denied, so the pointer now sits at 1.
    serve_pair("contend2", 1, 0);

    // D back-pressure on master 1 while master 0 waits.
    set_master(1, TL_A_GET, 4'd3, 3'd2, 32'h44, 32'h0);
    @(negedge clk);
    check("bp grant", grant_idx, 1);
    s_a_ready = 1'b1;
    @(negedge clk);
    s_a_ready = 1'b0; m_a_valid[1] = 1'b0;
    s_d_valid = 1'b1; s_d_opcode = TL_D_ACCESSACKDATA; s_d_source = 4'd3; s_d_data = 32'h5A5A1234;
    set_master(0, TL_A_GET, 4'd4, 3'd2, 32'h48, 32'h0);
    for (int c = 0; c < 5; c++) begin
      #1;
      check($sformatf("bp%0d s_d_ready", c), s_d_ready, 0);
      check($sformatf("bp%0d d_valid", c), m_d_valid, 2'b10);
      check($sformatf("bp%0d d_fields", c), {m_d_data, m_d_source, m_d_opcode}, {32'h5A5A1234, 4'd3, TL_D_ACCESSACKDATA});
      check($sformatf("bp%0d hold", c), {grant_idx, m_a_ready, s_a_valid}, {1'b1, 2'b00, 1'b0});
      @(negedge clk);
    end
    m_d_ready[1] = 1'b1;
    #1;
    check("bp release", s_d_ready, 1);
    @(negedge clk);
    s_d_valid = 1'b0; m_d_ready = '0; s_d_data = '0; s_d_source = '0;
    check("bp idle", busy, 0);
    serve_one("bp next", 0);

    // Reset while master 0 owns the slave with the pointer at 1.
    set_master(0, TL_A_GET, 4'd6, 3'd2, 32'h60, 32'h0);
    @(negedge clk);
    s_a_ready = 1'b1;
    @(negedge clk);
    s_a_ready = 1'b0; m_a_valid[0] = 1'b0;
    check("mid busy", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid rst busy", busy, 0);
    check("mid rst valids", {m_d_valid, m_a_ready, s_a_valid, s_d_ready, grant_idx}, 0);
    serve_pair("after rst", 0, 1);

    // Four masters requesting back to back must rotate strictly.
    for (int i = 0; i < NB; i++) cnt[i] = 0;
    b_m_a_valid = '1;
    for (int k = 0; k < 8; k++) begin
      for (int t = 0; t < 8 && b_s_a_valid !== 1'b1; t++) @(negedge clk);
      check($sformatf("starve%0d a_valid", k), b_s_a_valid, 1);
      check($sformatf("starve%0d grant", k), b_grant_idx, k % NB);
      cnt[b_grant_idx]++;
      b_s_a_ready = 1'b1;
      @(negedge clk);
      b_s_a_ready = 1'b0; b_s_d_valid = 1'b1; b_m_d_ready = '1;
      @(negedge clk);
      b_s_d_valid = 1'b0; b_m_d_ready = '0;
    end
    b_m_a_valid = '0;
    for (int i = 0; i < NB; i++) check($sformatf("starve cnt%0d", i), cnt[i], 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
